// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Shift-add multiply, restoring divide on magnitudes, followed by a sign-correction cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic             div_q;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        sign_a   = ~op[0] & operand_a[WIDTH-1];
        sign_b   = ~op[0] & operand_b[WIDTH-1];
        mag_a    = sign_a ? ('0 - operand_a) : operand_a;
        mag_b    = sign_b ? ('0 - operand_b) : operand_b;
        // Multiply: add multiplicand when the current multiplier LSB is set.
        add_sum  = acc + {1'b0, (q[0] ? m : '0)};
        // Divide: the extra accumulator bit keeps the trial subtraction from overflowing.
        shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff     = shifted - {1'b0, m};
        prod     = {acc[WIDTH-1:0], q};
        prod_fix = neg_q ? ('0 - prod) : prod;
        quot_fix = neg_q ? ('0 - q) : q;
        rem_fix  = neg_r ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            a_raw    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    if (start) begin
                        div_q    <= op[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= (operand_b == '0);
                        a_raw    <= operand_a;
                        count    <= '0;
                        acc      <= '0;
                        m        <= op[1] ? mag_b : mag_a;
                        q        <= op[1] ? mag_a : mag_b;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (div_q) begin
                        if (!diff[WIDTH]) begin
                            acc <= diff;
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= shifted;
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {1'b0, add_sum[WIDTH:1]};
                        q   <= {add_sum[0], q[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (div_q) begin
                        if (div_zero) begin
                            lo_r <= '1;
                            hi_r <= a_raw;
                        end else begin
                            lo_r <= quot_fix;
                            hi_r <= rem_fix;
                        end
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
